// File: rtl/alu_result_fifo.sv
// ALU result register plus first-word-fall-through buffer: computes N/Z/C/V at push time,
// hands {result, flags} to writeback over valid/ready and keeps a sticky overflow bit.
module alu_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              inValid,
  output logic              inReady,
  input  logic [31:0]       inResult,
  input  logic              inCarry,
  input  logic              inArith,
  input  logic              aMsb,
  input  logic              bMsb,
  output logic              outValid,
  input  logic              outReady,
  output logic [31:0]       outResult,
  output logic [3:0]        outFlags,
  output logic [PTR_W:0]    count,
  output logic              stickyOvf,
  input  logic              clearSticky
);

  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] result;
    logic        n;
    logic        z;
    logic        c;
    logic        v;
  } entry_t;

  entry_t              mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count_nxt;
  logic                push_c;
  logic                pop_c;
  entry_t              entry_c;

  // Handshakes depend only on registered state, so a pop never frees room for a same-cycle push.
  assign push_c = inValid & inReady;
  assign pop_c  = outValid & outReady;

  // Flag generation; C and V are forced low for logic operations.
  always_comb begin
    entry_c        = '0;
    entry_c.result = inResult;
    entry_c.n      = inResult[31];
    entry_c.z      = (inResult == 32'h0);
    entry_c.c      = inCarry & inArith;
    entry_c.v      = inArith & (aMsb == bMsb) & (inResult[31] != aMsb);
  end

  always_comb begin
    count_nxt = count;
    if (push_c && !pop_c) begin
      count_nxt = count + CNT_W'(1);
    end else if (!push_c && pop_c) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  // Storage and pointers; pointer width makes the wrap at DEPTH-1 implicit.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_c) begin
        mem[wr_ptr] <= entry_c;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Occupancy and the status flags derived from it, all registered.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      count    <= '0;
      inReady  <= 1'b1;
      outValid <= 1'b0;
    end else begin
      count    <= count_nxt;
      inReady  <= (count_nxt != CNT_W'(DEPTH));
      outValid <= (count_nxt != '0);
    end
  end

  // Sticky overflow: an accepted V=1 push beats a same-cycle clear.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stickyOvf <= 1'b0;
    end else if (push_c && entry_c.v) begin
      stickyOvf <= 1'b1;
    end else if (clearSticky) begin
      stickyOvf <= 1'b0;
    end
  end

  assign outResult = mem[rd_ptr].result;
  assign outFlags  = {mem[rd_ptr].n, mem[rd_ptr].z, mem[rd_ptr].c, mem[rd_ptr].v};

endmodule
